data_mem_bank: RTL and testbench
================================

# data_mem_bank

Synthesisable successor to the behavioural data memory used around the `mips` core: a parametrised word-addressed RAM with 4-bit byte-enable writes, a sequential post-reset clear engine, range checking, and a write-trace FIFO. The trace FIFO streams `{pc, word address, merged word}` records to a consumer. It sits on the core's M-stage data port (`m_data_*`, `m_inst_addr`). It replaces the single-cycle array clear and the `$display` write log with hardware behaviour.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words; must be a power of two, at least 2.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `TRACE_DEPTH`, default 8: trace FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_data_addr`  in  32  byte address from the M stage; bits [1:0] are ignored.
- `m_data_wdata`  in  32  write data, already lane-aligned.
- `m_data_byteen`  in  4  byte-lane write enables; 0 means no write.
- `m_inst_addr`  in  32  PC of the M-stage instruction, captured into the trace.
- `m_data_rdata`  out  32  combinational read of the addressed word.
- `busy`  out  1  high while the clear engine runs.
- `addr_err`  out  1  one-cycle registered pulse for an out-of-range write.
- `trace_valid`  out  1  FIFO head is valid.
- `trace_ready`  in  1  consumer accepts the head.
- `trace_pc`, `trace_addr`, `trace_data`  out  32 each  head record fields.
- `trace_overflow`  out  1  sticky flag: a trace record was dropped.

## Operation
- Word index: `idx = (m_data_addr - BASE_ADDR) >> 2`.
  - Address is in range iff `m_data_addr - BASE_ADDR < DEPTH_WORDS*4` (unsigned).
  - `fixed_addr = m_data_addr & ~32'h3`.
- State machine:
  - States: `CLEAR`, `RUN`.
  - `reset` forces `CLEAR` with `clr_cnt=0`.
  - In `CLEAR`, each cycle writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - At `clr_cnt==DEPTH_WORDS-1` the next state is `RUN`.
  - `busy = (state==CLEAR)`.
- Write, in `RUN` only:
  - Accepted when `|m_data_byteen` and the address is in range.
  - Merged word = old word, with lane k replaced by `m_data_wdata[8k+7:8k]` where `byteen[k]` is set.
  - The merged word is stored at the edge.
- Writes are silently discarded in `CLEAR`: no error, no trace.
- Out-of-range write in `RUN`:
  - No array change and no trace record.
  - `addr_err` is 1 in the following cycle.
- Read:
  - `m_data_rdata = mem[idx]` when in range and in `RUN`; otherwise 0.
  - A same-cycle write is not visible until the next cycle.
- Trace FIFO:
  - Every accepted write pushes `{m_inst_addr, fixed_addr, merged word}`.
  - Pop occurs when `trace_valid && trace_ready`.
  - Push while full with no pop: the record is dropped and `trace_overflow` is set until reset.
  - Push while full with a simultaneous pop: accepted; the count stays full.
  - Pointers are `$clog2(TRACE_DEPTH)` bits and wrap modulo `TRACE_DEPTH`; the count is one bit wider.
- Reset mid-operation (including mid-clear):
  - The FIFO is flushed.
  - `trace_overflow` and `addr_err` go to 0.
  - The clear restarts from word 0.

## Timing
- Reset values:
  - `busy`=1, `addr_err`=0, `trace_valid`=0, `trace_overflow`=0.
  - `trace_*` data = 0.
  - `m_data_rdata`=0.
- Clear latency:
  - `busy` stays high for exactly `DEPTH_WORDS` rising edges after the edge where `reset` is first sampled low.
  - The first `RUN` cycle follows.
- Write latency: 1 edge. The read of the same word in the next cycle returns the merged data.
- Trace latency:
  - `trace_valid` rises the cycle after the first push into an empty FIFO.
  - There is no fall-through.
- `addr_err`: asserted exactly one cycle per offending write, i.e. back-to-back for consecutive bad writes.

## Structure
- Package `data_mem_pkg` holds:
  - the state enum `dm_state_t {CLEAR, RUN}`;
  - the struct `trace_rec_t {pc, addr, data}`;
  - the function `merge_bytes(old, wdata, byteen)`.
- One sub-module, `trace_fifo`:
  - parameterised by `TRACE_DEPTH` and the element type;
  - signals valid/ready on the pop side, plus `push`, `full`, `overflow`.
- The top level holds the array, the clear FSM, range check and write merge.

## Test plan
- Reset, then `DEPTH_WORDS=16`: `busy` is high for 16 cycles, then low. Every in-range read returns 0.
- In `RUN`, write 32'hAABBCCDD with byteen 4'hF at 0x10, then byteen 4'b0101 with wdata 32'h11223344 at 0x12: final word at 0x10 is 32'hAA22CC44. The trace shows addr 0x10 twice, with the correct PCs.
- Write to `BASE_ADDR + DEPTH_WORDS*4` with byteen 4'h1: `addr_err` pulses for 1 cycle, the array is unchanged, no trace record.
- `TRACE_DEPTH=4`, `trace_ready=0`, 5 writes: 4 records are held and `trace_overflow`=1. Then a write with a simultaneous pop: accepted, count stays 4.
- Write during `CLEAR`: ignored. After `RUN`, the word reads 0 and there is no trace.
- Assert `reset` midway through the clear and midway through a trace drain: `busy` restarts the full count, `trace_valid`=0, overflow is cleared.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the M-stage data memory bank and its write-trace FIFO.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dm_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    // Replace each enabled byte lane of the old word with the matching write-data lane.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  byteen
    );
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (byteen[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Write-trace FIFO: push side never stalls, drops records when full, and latches a sticky overflow.
module trace_fifo
    import data_mem_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = trace_rec_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    output logic full,
    output logic valid,
    input  logic ready,
    output T     head,
    output logic overflow
);

    localparam int PW = $clog2(DEPTH);

    T               store [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           pop;
    logic           push_ok;

    assign valid   = (count != '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop     = valid && ready;
    // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign head    = valid ? store[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_bank.sv
// Word-addressed data RAM for the M stage: byte-enable writes, post-reset clear sweep,
// range checking and a write-trace stream.
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        busy,
    output logic        addr_err,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem [DEPTH_WORDS];
    dm_state_t     state;
    logic [AW-1:0] clr_cnt;

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          wr_req;
    logic          wr_acc;
    logic          wr_bad;
    logic [31:0]   merged;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    trace_rec_t    push_rec;
    trace_rec_t    head_rec;
    logic          fifo_full;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the same unsigned compare.
    assign off      = m_data_addr - BASE_ADDR;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[AW+1:2];

    assign busy   = (state == CLEAR);
    assign wr_req = (state == RUN) && (|m_data_byteen) && !reset;
    assign wr_acc = wr_req && in_range;
    assign wr_bad = wr_req && !in_range;
    assign merged = merge_bytes(mem[idx], m_data_wdata, m_data_byteen);

    assign m_data_rdata = ((state == RUN) && in_range) ? mem[idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= wr_bad;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(DEPTH_WORDS - 1)) state <= RUN;
                end
                RUN:     state <= RUN;
                default: state <= CLEAR;
            endcase
        end
    end

    // The clear sweep and M-stage writes share the single write port; they never overlap.
    assign mem_we    = busy || wr_acc;
    assign mem_waddr = busy ? clr_cnt : idx;
    assign mem_wdata = busy ? 32'h0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign push_rec.pc   = m_inst_addr;
    assign push_rec.addr = m_data_addr & ~32'h3;
    assign push_rec.data = merged;

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .T     (trace_rec_t)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_acc),
        .push_data (push_rec),
        .full      (fifo_full),
        .valid     (trace_valid),
        .ready     (trace_ready),
        .head      (head_rec),
        .overflow  (trace_overflow)
    );

    assign trace_pc   = head_rec.pc;
    assign trace_addr = head_rec.addr;
    assign trace_data = head_rec.data;

endmodule

// File: tb/tb_data_mem_bank.sv
// Directed-vector bench for data_mem_bank with a 16-word array and a 4-entry trace FIFO.
module tb_data_mem_bank;
    localparam int          DW   = 16;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TD   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        busy, addr_err, trace_valid, trace_ready, trace_overflow;
    logic [31:0] trace_pc, trace_addr, trace_data;

    int vectors = 0;
    int miscompares = 0;

    data_mem_bank #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE), .TRACE_DEPTH(TD)) dut (
        .clk(clk), .reset(reset),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata), .busy(busy), .addr_err(addr_err),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] pc);
        m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
        #1;
    endtask

    task automatic idle_at(input logic [31:0] a);
        drive(a, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic pop_one();
        trace_ready = 1'b1;
        tick();
        trace_ready = 1'b0;
        #1;
    endtask

    // Counts edges with busy high, bounded so a stuck clear still reaches the summary.
    task automatic count_busy(input int start, output int n);
        n = start;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    logic [31:0] exp_pc [4];
    logic [31:0] exp_dt [4];

    initial begin
        reset = 1'b1; trace_ready = 1'b0;
        idle_at(BASE);
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        chk("rst_trace_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst_overflow", {31'b0, trace_overflow}, 32'd0);
        chk("rst_trace_pc", trace_pc, 32'h0);
        chk("rst_trace_addr", trace_addr, 32'h0);
        chk("rst_trace_data", trace_data, 32'h0);
        chk("rst_rdata", m_data_rdata, 32'h0);

        // Release reset with a write pending: it must be ignored while clearing.
        reset = 1'b0;
        drive(BASE + 32'h3C, 32'hDEAD_BEEF, 4'hF, 32'h0040_0000);
        tick();
        chk("clear_rdata", m_data_rdata, 32'h0);
        idle_at(BASE);
        count_busy(1, n);
        chk("clear_cycles", n, 32'd16);
        chk("clear_no_trace", {31'b0, trace_valid}, 32'd0);
        chk("clear_no_err", {31'b0, addr_err}, 32'd0);
        for (int i = 0; i < DW; i++) begin
            idle_at(BASE + 32'(i * 4));
            chk($sformatf("zero_word%0d", i), m_data_rdata, 32'h0);
        end

        // Full-word write then partial byte-lane write to the same word.
        drive(BASE + 32'h10, 32'hAABB_CCDD, 4'hF, 32'h0040_0100);
        tick();
        chk("wr_full_rd", m_data_rdata, 32'hAABB_CCDD);
        chk("trace_valid_1", {31'b0, trace_valid}, 32'd1);
        drive(BASE + 32'h12, 32'h1122_3344, 4'b0101, 32'h0040_0104);
        tick();
        idle_at(BASE + 32'h10);
        chk("wr_merge_rd", m_data_rdata, 32'hAA22_CC44);
        chk("tr0_pc", trace_pc, 32'h0040_0100);
        chk("tr0_addr", trace_addr, BASE + 32'h10);
        chk("tr0_data", trace_data, 32'hAABB_CCDD);
        pop_one();
        chk("tr1_pc", trace_pc, 32'h0040_0104);
        chk("tr1_addr", trace_addr, BASE + 32'h10);
        chk("tr1_data", trace_data, 32'hAA22_CC44);
        pop_one();
        chk("tr_empty", {31'b0, trace_valid}, 32'd0);

        // Out-of-range writes: one past the top, then below base, back to back.
        drive(BASE + 32'h40, 32'h0000_0055, 4'h1, 32'h0040_0200);
        tick();
        chk("oor_err1", {31'b0, addr_err}, 32'd1);
        drive(BASE - 32'h4, 32'h0000_0066, 4'h1, 32'h0040_0204);
        tick();
        chk("oor_err2", {31'b0, addr_err}, 32'd1);
        idle_at(BASE);
        chk("oor_word0", m_data_rdata, 32'h0);
        idle_at(BASE + 32'h3C);
        chk("oor_word15", m_data_rdata, 32'h0);
        tick();
        chk("oor_err_drop", {31'b0, addr_err}, 32'd0);
        chk("oor_no_trace", {31'b0, trace_valid}, 32'd0);
        idle_at(BASE + 32'h40);
        chk("oor_rdata", m_data_rdata, 32'h0);

        // Fill the 4-entry FIFO, overflow it, then push with a simultaneous pop.
        for (int i = 0; i < 5; i++) begin
            drive(BASE + 32'(i * 4), 32'(i + 1), 4'hF, 32'h0050_0000 + 32'(i * 4));
            tick();
        end
        idle_at(BASE + 32'h10);
        chk("ovf_flag", {31'b0, trace_overflow}, 32'd1);
        chk("ovf_word4", m_data_rdata, 32'd5);
        chk("ovf_head_pc", trace_pc, 32'h0050_0000);
        trace_ready = 1'b1;
        drive(BASE + 32'h14, 32'd6, 4'hF, 32'h0050_0014);
        tick();
        trace_ready = 1'b0;
        idle_at(BASE);
        exp_pc = '{32'h0050_0004, 32'h0050_0008, 32'h0050_000C, 32'h0050_0014};
        exp_dt = '{32'd2, 32'd3, 32'd4, 32'd6};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'b0, trace_valid}, 32'd1);
            chk($sformatf("drain%0d_pc", i), trace_pc, exp_pc[i]);
            chk($sformatf("drain%0d_data", i), trace_data, exp_dt[i]);
            pop_one();
        end
        chk("drain_empty", {31'b0, trace_valid}, 32'd0);
        chk("ovf_sticky", {31'b0, trace_overflow}, 32'd1);

        // Reset in the middle of a trace drain.
        drive(BASE + 32'h20, 32'h7, 4'hF, 32'h0060_0000); tick();
        drive(BASE + 32'h24, 32'h8, 4'hF, 32'h0060_0004); tick();
        idle_at(BASE);
        pop_one();
        chk("mid_drain_valid", {31'b0, trace_valid}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rst2_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst2_overflow", {31'b0, trace_overflow}, 32'd0);
        chk("rst2_busy", {31'b0, busy}, 32'd1);
        chk("rst2_trace_pc", trace_pc, 32'h0);

        // Reset in the middle of the clear sweep restarts the full count.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midclr_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(0, n);
        chk("reclear_cycles", n, 32'd16);
        idle_at(BASE + 32'h10);
        chk("reclear_word4", m_data_rdata, 32'h0);
        idle_at(BASE + 32'h20);
        chk("reclear_word8", m_data_rdata, 32'h0);
        chk("reclear_no_trace", {31'b0, trace_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
